// File: rtl/i2c_txn_sequencer.sv
// Breaks one whole I2C transaction into START / ADDR / DATA|READ xN / STOP commands
// for I2C_Master, running the per-command ready/strobe handshake and a ready watchdog.
module i2c_txn_sequencer #(
  parameter int LEN_W     = 4,
  parameter int TIMEOUT_W = 16,
  parameter int TIMEOUT   = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [6:0]       req_addr,
  input  logic             req_rw,
  input  logic [LEN_W-1:0] req_len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             err,
  output logic             busy,
  output logic             m_start,
  output logic             m_stop,
  output logic             m_i2c_en,
  output logic [7:0]       m_tx_data,
  input  logic [7:0]       m_rx_data,
  input  logic             m_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_WDATA,
    S_RDATA,
    S_STOP
  } state_t;

  // Each command walks RDY (wait for master idle) -> EN (strobe until accepted) -> WAIT.
  typedef enum logic [1:0] {
    P_RDY,
    P_EN,
    P_WAIT
  } phase_t;

  state_t               state, state_n;
  phase_t               phase, phase_n;
  logic                 rw_q, rw_n;
  logic [LEN_W-1:0]     cnt_q, cnt_n;
  logic [7:0]           tx_q, tx_n;
  logic [TIMEOUT_W-1:0] wd_q, wd_n;
  logic                 err_q, err_n;
  logic                 done_q, done_n;
  logic                 rdv_q, rdv_n;
  logic [7:0]           rdd_q, rdd_n;

  logic active;
  logic stuck;
  logic timeout;
  logic wr_take;
  logic issue_go;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      phase  <= P_RDY;
      rw_q   <= 1'b0;
      cnt_q  <= '0;
      tx_q   <= 8'h00;
      wd_q   <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
      rdv_q  <= 1'b0;
      rdd_q  <= 8'h00;
    end else begin
      state  <= state_n;
      phase  <= phase_n;
      rw_q   <= rw_n;
      cnt_q  <= cnt_n;
      tx_q   <= tx_n;
      wd_q   <= wd_n;
      err_q  <= err_n;
      done_q <= done_n;
      rdv_q  <= rdv_n;
      rdd_q  <= rdd_n;
    end
  end

  // The watchdog only runs while m_ready sits at the wrong level for the current phase;
  // waiting on wr_valid with the master idle is not a stall it cares about.
  always_comb begin
    active   = (state != S_IDLE);
    stuck    = active && (((phase == P_RDY)  && !m_ready) ||
                          ((phase == P_EN)   &&  m_ready) ||
                          ((phase == P_WAIT) && !m_ready));
    timeout  = stuck && (wd_q == TIMEOUT_W'(TIMEOUT - 1));
    wr_take  = (state == S_WDATA) && (phase == P_RDY) && m_ready && wr_valid;
    issue_go = (phase == P_RDY) && m_ready && ((state != S_WDATA) || wr_valid);
  end

  always_comb begin
    state_n = state;
    phase_n = phase;
    rw_n    = rw_q;
    cnt_n   = cnt_q;
    tx_n    = tx_q;
    wd_n    = stuck ? (wd_q + TIMEOUT_W'(1)) : '0;
    err_n   = err_q;
    done_n  = 1'b0;
    rdv_n   = 1'b0;
    rdd_n   = rdd_q;

    if (state == S_IDLE) begin
      wd_n = '0;
      if (req_valid) begin
        rw_n    = req_rw;
        cnt_n   = req_len;
        tx_n    = {req_addr, req_rw};
        err_n   = 1'b0;
        state_n = S_START;
        phase_n = P_RDY;
      end
    end else if (timeout) begin
      // A stall during STOP itself gives up straight to IDLE rather than retrying.
      err_n   = 1'b1;
      wd_n    = '0;
      phase_n = P_RDY;
      if (state == S_STOP) begin
        state_n = S_IDLE;
        done_n  = 1'b1;
      end else begin
        state_n = S_STOP;
      end
    end else begin
      case (phase)
        P_RDY: begin
          if (issue_go) begin
            phase_n = P_EN;
            wd_n    = '0;
            if (state == S_WDATA) tx_n = wr_data;
          end
        end
        P_EN: begin
          if (!m_ready) begin
            phase_n = P_WAIT;
            wd_n    = '0;
          end
        end
        P_WAIT: begin
          if (m_ready) begin
            phase_n = P_RDY;
            wd_n    = '0;
            case (state)
              S_START: state_n = S_ADDR;
              S_ADDR: begin
                if (cnt_q == '0)  state_n = S_STOP;
                else if (rw_q)    state_n = S_RDATA;
                else              state_n = S_WDATA;
              end
              S_WDATA, S_RDATA: begin
                cnt_n = cnt_q - LEN_W'(1);
                if (state == S_RDATA) begin
                  rdv_n = 1'b1;
                  rdd_n = m_rx_data;
                end
                if (cnt_q == LEN_W'(1)) state_n = S_STOP;
              end
              S_STOP: begin
                state_n = S_IDLE;
                done_n  = 1'b1;
              end
              default: state_n = S_IDLE;
            endcase
          end
        end
        default: phase_n = P_RDY;
      endcase
    end
  end

  // Command fields come straight from state so they hold steady through EN and WAIT.
  always_comb begin
    req_ready = (state == S_IDLE);
    busy      = active;
    m_i2c_en  = active && (phase == P_EN);
    m_start   = (state == S_START) || (state == S_RDATA);
    m_stop    = (state == S_STOP)  || (state == S_RDATA);
    m_tx_data = tx_q;
    wr_ready  = wr_take;
    rd_data   = rdd_q;
    rd_valid  = rdv_q;
    done      = done_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer with a behavioural I2C_Master model that logs
// every strobed command as {m_start, m_stop, m_tx_data}.
module tb_i2c_txn_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [6:0] req_addr = 7'h00;
  logic       req_rw = 1'b0;
  logic [3:0] req_len = 4'h0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       done;
  logic       err;
  logic       busy;
  logic       m_start;
  logic       m_stop;
  logic       m_i2c_en;
  logic [7:0] m_tx_data;
  logic [7:0] m_rx_data = 8'h00;
  logic       m_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  logic [9:0] cmd_log[$];
  logic [7:0] rd_src[$];
  logic [7:0] rd_log[$];
  logic [7:0] wr_bytes[$];
  int         wr_idx = 0;
  logic       wr_hold = 1'b0;
  logic       stall = 1'b0;
  int         busy_cnt = 0;
  int         done_cnt = 0;
  int         wr_cnt = 0;

  i2c_txn_sequencer #(.LEN_W(4), .TIMEOUT_W(16), .TIMEOUT(100)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_rw(req_rw), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .err(err), .busy(busy),
    .m_start(m_start), .m_stop(m_stop), .m_i2c_en(m_i2c_en),
    .m_tx_data(m_tx_data), .m_rx_data(m_rx_data), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  // Master model: drops ready on each strobe, stays busy two cycles, then re-arms.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!reset) begin
        m_ready  = 1'b1;
        busy_cnt = 0;
      end else if (stall) begin
        m_ready = 1'b0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) m_ready = 1'b1;
      end else if (m_i2c_en && m_ready) begin
        cmd_log.push_back({m_start, m_stop, m_tx_data});
        m_ready  = 1'b0;
        busy_cnt = 2;
        if (m_start && m_stop) m_rx_data = (rd_src.size() > 0) ? rd_src.pop_front() : 8'hEE;
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  // Write-byte source: advances one byte per wr_valid&wr_ready handshake.
  initial begin
    bit take;
    forever begin
      @(negedge clk);
      take = wr_valid && wr_ready;
      @(posedge clk); #1;
      if (take) wr_idx++;
      wr_valid = reset && !wr_hold && (wr_idx < wr_bytes.size());
      wr_data  = wr_valid ? wr_bytes[wr_idx] : 8'h00;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #3;
      if (reset) begin
        if (done) done_cnt++;
        if (rd_valid) rd_log.push_back(rd_data);
        if (wr_valid && wr_ready) wr_cnt++;
      end
    end
  end

  task automatic send_req(input logic [6:0] a, input logic rw, input logic [3:0] len);
    int n;
    @(negedge clk);
    req_addr  = a;
    req_rw    = rw;
    req_len   = len;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
  endtask

  task automatic wait_cmds(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (cmd_log.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_handshake req_ready=%b busy=%b required 1/0", req_ready, busy);
    end
    checks++;
    if ({m_start, m_stop, m_i2c_en, m_tx_data} !== 11'h000) begin
      failures++;
      $display("[TB] FAIL reset_master got %b%b%b tx=%h required 000 tx=00", m_start, m_stop, m_i2c_en, m_tx_data);
    end
    checks++;
    if ({done, err, rd_valid, wr_ready, rd_data} !== 12'h000) begin
      failures++;
      $display("[TB] FAIL reset_status done=%b err=%b rdv=%b wrr=%b rd=%h required all 0", done, err, rd_valid, wr_ready, rd_data);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write;
    logic [9:0] exp[6];
    int d0, w0;
    bit ok;
    exp = '{10'h2AA, 10'h0AA, 10'h001, 10'h002, 10'h003, 10'h004};
    cmd_log.delete();
    wr_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
    wr_idx = 0;
    d0 = done_cnt;
    w0 = wr_cnt;
    send_req(7'h55, 1'b0, 4'd4);
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL write_accept busy=%b req_ready=%b required 1/0", busy, req_ready);
    end
    wait_done(2000, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL write_done_timeout got no done required done pulse");
    end
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_log.size() !== 7) begin
      failures++;
      $display("[TB] FAIL write_cmd_count got %0d required 7", cmd_log.size());
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (cmd_log[i] !== exp[i]) begin
        failures++;
        $display("[TB] FAIL write_cmd%0d got %h required %h", i, cmd_log[i], exp[i]);
      end
    end
    checks++;
    if (cmd_log[6][9:8] !== 2'b01) begin
      failures++;
      $display("[TB] FAIL write_stop got %b required 01", cmd_log[6][9:8]);
    end
    checks++;
    if (done_cnt - d0 !== 1 || wr_cnt - w0 !== 4 || err !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL write_status done=%0d wr=%0d err=%b rr=%b required 1/4/0/1", done_cnt - d0, wr_cnt - w0, err, req_ready);
    end
  endtask

  task automatic test_read;
    logic [9:0] exp[6];
    logic [7:0] rexp[3];
    int d0, w0;
    bit ok;
    exp  = '{10'h2AB, 10'h0AB, 10'h3AB, 10'h3AB, 10'h3AB, 10'h1AB};
    rexp = '{8'hA1, 8'hB2, 8'hC3};
    cmd_log.delete();
    rd_log.delete();
    rd_src = '{8'hA1, 8'hB2, 8'hC3};
    d0 = done_cnt;
    w0 = wr_cnt;
    send_req(7'h55, 1'b1, 4'd3);
    wait_done(2000, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || cmd_log.size() !== 6) begin
      failures++;
      $display("[TB] FAIL read_cmd_count got %0d done=%b required 6 done=1", cmd_log.size(), ok);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (cmd_log[i] !== exp[i]) begin
        failures++;
        $display("[TB] FAIL read_cmd%0d got %h required %h", i, cmd_log[i], exp[i]);
      end
    end
    checks++;
    if (rd_log.size() !== 3) begin
      failures++;
      $display("[TB] FAIL read_rd_count got %0d required 3", rd_log.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_log[i] !== rexp[i]) begin
        failures++;
        $display("[TB] FAIL read_byte%0d got %h required %h", i, rd_log[i], rexp[i]);
      end
    end
    checks++;
    if (done_cnt - d0 !== 1 || wr_cnt !== w0) begin
      failures++;
      $display("[TB] FAIL read_status done=%0d wr=%0d required 1/0", done_cnt - d0, wr_cnt - w0);
    end
  endtask

  task automatic test_probe;
    int d0, w0;
    bit ok;
    cmd_log.delete();
    rd_log.delete();
    d0 = done_cnt;
    w0 = wr_cnt;
    send_req(7'h2A, 1'b0, 4'd0);
    wait_done(2000, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || cmd_log.size() !== 3 || cmd_log[0] !== 10'h254 || cmd_log[1] !== 10'h054 || cmd_log[2] !== 10'h154) begin
      failures++;
      $display("[TB] FAIL probe_cmds n=%0d %h %h %h required 3: 254 054 154", cmd_log.size(), cmd_log[0], cmd_log[1], cmd_log[2]);
    end
    checks++;
    if (done_cnt - d0 !== 1 || wr_cnt !== w0 || rd_log.size() !== 0) begin
      failures++;
      $display("[TB] FAIL probe_status done=%0d wr=%0d rd=%0d required 1/0/0", done_cnt - d0, wr_cnt - w0, rd_log.size());
    end
  endtask

  task automatic test_timeout;
    int d0, w0, n;
    bit ok;
    cmd_log.delete();
    wr_bytes = '{8'h11, 8'h22};
    wr_idx = 0;
    d0 = done_cnt;
    w0 = wr_cnt;
    send_req(7'h55, 1'b0, 4'd2);
    wait_cmds(2, 500, ok);
    stall = 1'b1;
    n = 0;
    while (err !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n < 95 || n > 110) begin
      failures++;
      $display("[TB] FAIL timeout_latency got %0d cycles required about 100", n);
    end
    stall = 1'b0;
    wait_done(500, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || cmd_log.size() !== 3 || cmd_log[2] !== 10'h1AA) begin
      failures++;
      $display("[TB] FAIL timeout_stop n=%0d last=%h done=%b required 3 last=1aa done=1", cmd_log.size(), cmd_log[2], ok);
    end
    checks++;
    if (err !== 1'b1 || wr_cnt !== w0 || done_cnt - d0 !== 1) begin
      failures++;
      $display("[TB] FAIL timeout_status err=%b wr=%0d done=%0d required 1/0/1", err, wr_cnt - w0, done_cnt - d0);
    end
    wr_bytes.delete();
    wr_idx = 0;
  endtask

  task automatic test_wr_stall;
    logic [9:0] exp[4];
    int d0, w0;
    bit ok;
    exp = '{10'h278, 10'h078, 10'h05A, 10'h0C3};
    cmd_log.delete();
    wr_bytes = '{8'h5A, 8'hC3};
    wr_idx = 0;
    d0 = done_cnt;
    w0 = wr_cnt;
    send_req(7'h3C, 1'b0, 4'd2);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL err_clear_on_accept got %b required 0", err);
    end
    wait_cmds(3, 500, ok);
    wr_hold = 1'b1;
    req_addr  = 7'h11;
    req_rw    = 1'b1;
    req_len   = 4'd1;
    req_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL busy_req_ready got %b required 0", req_ready);
    end
    req_valid = 1'b0;
    repeat (500) @(negedge clk);
    checks++;
    if (cmd_log.size() !== 3 || err !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stall_hold n=%0d err=%b busy=%b required 3/0/1", cmd_log.size(), err, busy);
    end
    wr_hold = 1'b0;
    wait_done(500, ok);
    repeat (20) @(negedge clk);
    checks++;
    if (!ok || cmd_log.size() !== 5 || cmd_log[4][9:8] !== 2'b01) begin
      failures++;
      $display("[TB] FAIL stall_resume n=%0d done=%b required 5 cmds ending in STOP", cmd_log.size(), ok);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cmd_log[i] !== exp[i]) begin
        failures++;
        $display("[TB] FAIL stall_cmd%0d got %h required %h", i, cmd_log[i], exp[i]);
      end
    end
    checks++;
    if (wr_cnt - w0 !== 2 || done_cnt - d0 !== 1 || err !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_status wr=%0d done=%0d err=%b busy=%b required 2/1/0/0", wr_cnt - w0, done_cnt - d0, err, busy);
    end
  endtask

  task automatic test_reset_mid;
    int d0;
    bit ok;
    cmd_log.delete();
    wr_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
    wr_idx = 0;
    send_req(7'h55, 1'b0, 4'd4);
    wait_cmds(4, 500, ok);
    d0 = done_cnt;
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || m_i2c_en !== 1'b0 || {m_start, m_stop} !== 2'b00 || m_tx_data !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_mid_outputs busy=%b rr=%b en=%b ss=%b%b tx=%h required 0/1/0/00/00", busy, req_ready, m_i2c_en, m_start, m_stop, m_tx_data);
    end
    checks++;
    if (done !== 1'b0 || wr_ready !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_status done=%b wrr=%b err=%b required 0/0/0", done, wr_ready, err);
    end
    wr_bytes.delete();
    wr_idx = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt !== d0 || cmd_log.size() !== 4) begin
      failures++;
      $display("[TB] FAIL reset_mid_no_stop done=%0d cmds=%0d required %0d/4", done_cnt, cmd_log.size(), d0);
    end
  endtask

  task automatic test_back_to_back;
    int d0;
    bit ok;
    cmd_log.delete();
    d0 = done_cnt;
    send_req(7'h2A, 1'b0, 4'd0);
    send_req(7'h15, 1'b1, 4'd0);
    wait_done(2000, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || done_cnt - d0 !== 2 || cmd_log.size() !== 6) begin
      failures++;
      $display("[TB] FAIL b2b_count done=%0d cmds=%0d required 2/6", done_cnt - d0, cmd_log.size());
    end
    checks++;
    if (cmd_log[0] !== 10'h254 || cmd_log[3] !== 10'h22B || cmd_log[4] !== 10'h02B || cmd_log[5] !== 10'h12B) begin
      failures++;
      $display("[TB] FAIL b2b_cmds got %h %h %h %h required 254 22b 02b 12b", cmd_log[0], cmd_log[3], cmd_log[4], cmd_log[5]);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_probe();
    test_timeout();
    test_wr_stall();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
